// File: rtl/exec_pkg.sv
// Shared types and encodings for the execute stage: op classes, sub-op codes,
// FSM states and the load/store lane helper.
package exec_pkg;

    typedef enum logic [2:0] {
        OP_ALU    = 3'd0,
        OP_BRANCH = 3'd1,
        OP_JUMP   = 3'd2,
        OP_LOAD   = 3'd3,
        OP_STORE  = 3'd4,
        OP_MUL    = 3'd5
    } op_class_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MEM_REQ,
        S_MEM_WAIT,
        S_MUL,
        S_RESP
    } state_e;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SRL  = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;

    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_D  = 3'b011;
    localparam logic [2:0] MEM_BU = 3'b100;
    localparam logic [2:0] MEM_HU = 3'b101;
    localparam logic [2:0] MEM_WU = 3'b110;

    // Byte lane of an access inside the data word; a 32-bit bus has only four lanes.
    function automatic logic [2:0] lane_off(input logic [2:0] addr_lo, input logic wide);
        return wide ? addr_lo : {1'b0, addr_lo[1:0]};
    endfunction

endpackage

// File: rtl/exec_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, XLEN cycles,
// returns the low XLEN bits of a*b with a one-cycle done pulse.
module exec_mul_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] product
);

    localparam int CW = $clog2(XLEN);

    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] mcand;
    logic [XLEN-1:0] mplier;
    logic [CW-1:0]   cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else begin
            done <= 1'b0;
            if (start && !busy) begin
                busy   <= 1'b1;
                acc    <= '0;
                mcand  <= a;
                mplier <= b;
                cnt    <= '0;
            end else if (busy) begin
                if (mplier[0])
                    acc <= acc + mcand;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
                if (cnt == CW'(XLEN - 1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign product = acc;

endmodule

// File: rtl/execute_unit.sv
// Handshaked execute stage: ALU, branch/jump resolution, load/store port with
// wait states and an optional iterative multiplier, one instruction at a time.
module execute_unit
    import exec_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter bit              MUL_EN   = 1'b1,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        op_class,
    input  logic              is_reg,
    input  logic [XLEN-1:0]   operand_a,
    input  logic [XLEN-1:0]   operand_b,
    input  logic [XLEN-1:0]   imm,
    input  logic [XLEN-1:0]   store_data,
    input  logic [4:0]        dest_i,
    input  logic [2:0]        func3,
    input  logic              func7,
    input  logic [XLEN-1:0]   curr_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   result,
    output logic [4:0]        dest_o,
    output logic              wb_en,
    output logic [XLEN-1:0]   next_pc,
    output logic              redirect,
    output logic              trap,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_wstrb,
    input  logic              mem_rsp_valid,
    input  logic [XLEN-1:0]   mem_rdata
);

    localparam int SHW   = $clog2(XLEN);
    localparam int STRBW = XLEN / 8;

    state_e          state;
    op_class_e       op;
    logic            accept;
    logic [XLEN-1:0] pc_plus4, br_target, jmp_target, acc_addr;
    logic [XLEN-1:0] alu_res, ld_shift, ld_val, mul_product;
    logic [SHW-1:0]  shamt;
    logic            br_taken, jmp_mis, acc_bad, acc_mis, mul_done;
    logic [7:0]      sz_mask;
    logic [2:0]      align_mask, lane_c, lane_q, ld_f3;

    assign op         = op_class_e'(op_class);
    assign in_ready   = (state == S_IDLE);
    assign accept     = in_ready && in_valid;
    assign pc_plus4   = curr_pc + XLEN'(4);
    assign br_target  = curr_pc + imm;
    assign shamt      = operand_b[SHW-1:0];
    assign acc_addr   = operand_a + imm;
    assign lane_c     = lane_off(acc_addr[2:0], XLEN == 64);
    assign jmp_target = is_reg ? ((operand_a + imm) & ~XLEN'(1)) : br_target;
    assign jmp_mis    = |jmp_target[1:0];
    assign acc_mis    = |(acc_addr[2:0] & align_mask);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        alu_res = '0;
        case (func3)
            F3_ADD:  alu_res = func7 ? operand_a - operand_b : operand_a + operand_b;
            F3_SLL:  alu_res = operand_a << shamt;
            F3_SLT:  alu_res = XLEN'($signed(operand_a) < $signed(operand_b));
            F3_SLTU: alu_res = XLEN'(operand_a < operand_b);
            F3_XOR:  alu_res = operand_a ^ operand_b;
            F3_SRL:  alu_res = func7 ? XLEN'($signed(operand_a) >>> shamt) : operand_a >> shamt;
            F3_OR:   alu_res = operand_a | operand_b;
            F3_AND:  alu_res = operand_a & operand_b;
            default: alu_res = '0;
        endcase

        br_taken = 1'b0;
        case (func3)
            BR_EQ:   br_taken = (operand_a == operand_b);
            BR_NE:   br_taken = (operand_a != operand_b);
            BR_LT:   br_taken = ($signed(operand_a) < $signed(operand_b));
            BR_GE:   br_taken = ($signed(operand_a) >= $signed(operand_b));
            BR_LTU:  br_taken = (operand_a < operand_b);
            BR_GEU:  br_taken = (operand_a >= operand_b);
            default: br_taken = 1'b0;
        endcase

        sz_mask    = 8'h00;
        align_mask = 3'b000;
        acc_bad    = 1'b0;
        case (func3)
            MEM_B, MEM_BU:  begin sz_mask = 8'h01; align_mask = 3'b000; end
            MEM_H, MEM_HU:  begin sz_mask = 8'h03; align_mask = 3'b001; end
            MEM_W, MEM_WU:  begin sz_mask = 8'h0F; align_mask = 3'b011; end
            MEM_D: begin
                sz_mask    = 8'hFF;
                align_mask = 3'b111;
                acc_bad    = (XLEN != 64);
            end
            default: acc_bad = 1'b1;
        endcase
        // Stores only have the signed-size encodings.
        if (op == OP_STORE && func3[2])
            acc_bad = 1'b1;
    end

    assign ld_shift = mem_rdata >> {lane_q, 3'b000};

    always_comb begin
        case (ld_f3)
            MEM_B:   ld_val = XLEN'($signed(ld_shift[7:0]));
            MEM_BU:  ld_val = XLEN'(ld_shift[7:0]);
            MEM_H:   ld_val = XLEN'($signed(ld_shift[15:0]));
            MEM_HU:  ld_val = XLEN'(ld_shift[15:0]);
            MEM_W:   ld_val = XLEN'($signed(ld_shift[31:0]));
            MEM_WU:  ld_val = XLEN'(ld_shift[31:0]);
            default: ld_val = ld_shift;
        endcase
    end

    generate
        if (MUL_EN) begin : g_mul
            logic mul_busy;
            logic mul_start;
            assign mul_start = accept && (op == OP_MUL) && !mul_busy;
            exec_mul_iter #(.XLEN(XLEN)) u_mul (
                .clk     (clk),
                .reset   (reset),
                .start   (mul_start),
                .a       (operand_a),
                .b       (operand_b),
                .busy    (mul_busy),
                .done    (mul_done),
                .product (mul_product)
            );
        end else begin : g_no_mul
            assign mul_done    = 1'b0;
            assign mul_product = '0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            out_valid     <= 1'b0;
            result        <= '0;
            dest_o        <= '0;
            wb_en         <= 1'b0;
            next_pc       <= RESET_PC;
            redirect      <= 1'b0;
            trap          <= 1'b0;
            mem_req_valid <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_wstrb     <= '0;
            ld_f3         <= '0;
            lane_q        <= '0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    dest_o    <= dest_i;
                    result    <= '0;
                    wb_en     <= 1'b0;
                    trap      <= 1'b0;
                    next_pc   <= pc_plus4;
                    redirect  <= 1'b0;
                    out_valid <= 1'b1;
                    state     <= S_RESP;
                    case (op)
                        OP_ALU: begin
                            result <= alu_res;
                            wb_en  <= (dest_i != 5'd0);
                        end
                        OP_BRANCH: if (br_taken) begin
                            next_pc  <= br_target;
                            redirect <= 1'b1;
                        end
                        OP_JUMP: begin
                            result   <= pc_plus4;
                            next_pc  <= jmp_target;
                            redirect <= 1'b1;
                            trap     <= jmp_mis;
                            wb_en    <= !jmp_mis && (dest_i != 5'd0);
                        end
                        OP_LOAD, OP_STORE: begin
                            if (acc_bad || acc_mis) begin
                                trap <= 1'b1;
                            end else begin
                                out_valid     <= 1'b0;
                                state         <= S_MEM_REQ;
                                mem_req_valid <= 1'b1;
                                mem_we        <= (op == OP_STORE);
                                mem_addr      <= acc_addr & ~XLEN'(STRBW - 1);
                                mem_wdata     <= store_data << {lane_c, 3'b000};
                                mem_wstrb     <= STRBW'(sz_mask << lane_c);
                                ld_f3         <= func3;
                                lane_q        <= lane_c;
                            end
                        end
                        OP_MUL: begin
                            if (MUL_EN) begin
                                out_valid <= 1'b0;
                                state     <= S_MUL;
                            end else begin
                                trap <= 1'b1;
                            end
                        end
                        default: trap <= 1'b1;
                    endcase
                end
                S_MEM_REQ: if (mem_req_ready) begin
                    mem_req_valid <= 1'b0;
                    if (mem_we) begin
                        out_valid <= 1'b1;
                        state     <= S_RESP;
                    end else begin
                        state <= S_MEM_WAIT;
                    end
                end
                S_MEM_WAIT: if (mem_rsp_valid) begin
                    result    <= ld_val;
                    wb_en     <= (dest_o != 5'd0);
                    out_valid <= 1'b1;
                    state     <= S_RESP;
                end
                S_MUL: if (mul_done) begin
                    result    <= mul_product;
                    wb_en     <= (dest_o != 5'd0);
                    out_valid <= 1'b1;
                    state     <= S_RESP;
                end
                S_RESP: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
